// File: rtl/spi_slave_tx_if.sv
// spi_slave_tx_if: SPI pins plus transmit-word handshake and status pulses
interface spi_slave_tx_if #(parameter int DATA_W = 12);
  logic              sclk_n;
  logic              cs_n;
  logic              from_device;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              busy;
  logic              frame_done;
  logic              underrun;
  logic              abort;
  modport slave (
    input  sclk_n, cs_n, tx_data, tx_valid,
    output from_device, tx_ready, busy, frame_done, underrun, abort
  );
  modport master (
    output sclk_n, cs_n, tx_data, tx_valid,
    input  from_device, tx_ready, busy, frame_done, underrun, abort
  );
endinterface

// File: rtl/spi_slave_tx.sv
// spi_slave_tx: SPI slave transmitter, one-word holding register, MSB-first shifter
module spi_slave_tx #(
  parameter int DATA_W      = 12,
  parameter int SYNC_STAGES = 2
) (
  input logic          clk,
  input logic          rst,
  spi_slave_tx_if.slave bus
);
  localparam int CW = $clog2(DATA_W + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, TAIL} state_t;
  state_t            state, state_n;
  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync;
  logic              sclk_q, cs_q;
  logic              sclk_rise, cs_fall, cs_rise;
  logic [DATA_W-1:0] hold, last_sent, last_n, shifter, shifter_n;
  logic              full, full_n, wr, start;
  logic [CW-1:0]     cnt, cnt_n;
  logic              dout, dout_n, done, done_n, under, under_n, abrt, abrt_n;
  assign sclk_rise = sclk_sync[SYNC_STAGES-1] & ~sclk_q;
  assign cs_fall   = ~cs_sync[SYNC_STAGES-1] & cs_q;
  assign cs_rise   = cs_sync[SYNC_STAGES-1] & ~cs_q;
  assign wr        = bus.tx_valid & ~full;
  assign start     = (state == IDLE) & cs_fall;
  assign full_n    = wr | (full & ~start);
  // Pin synchronizers followed by one edge-detect flop per pin
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync <= '1;
      cs_sync   <= '1;
      sclk_q    <= 1'b1;
      cs_q      <= 1'b1;
    end else begin
      sclk_sync <= (sclk_sync << 1) | SYNC_STAGES'(bus.sclk_n);
      cs_sync   <= (cs_sync << 1) | SYNC_STAGES'(bus.cs_n);
      sclk_q    <= sclk_sync[SYNC_STAGES-1];
      cs_q      <= cs_sync[SYNC_STAGES-1];
    end
  end
  // Holding register; a write in the frame-start cycle stays held for the next frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold <= '0;
      full <= 1'b0;
    end else begin
      hold <= wr ? bus.tx_data : hold;
      full <= full_n;
    end
  end
  // Frame state and datapath register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      shifter   <= '0;
      last_sent <= '0;
      cnt       <= '0;
      dout      <= 1'b0;
      done      <= 1'b0;
      under     <= 1'b0;
      abrt      <= 1'b0;
    end else begin
      state     <= state_n;
      shifter   <= shifter_n;
      last_sent <= last_n;
      cnt       <= cnt_n;
      dout      <= dout_n;
      done      <= done_n;
      under     <= under_n;
      abrt      <= abrt_n;
    end
  end
  // Next-state: load on cs_n fall, shift on sclk_n rise, finish or abort on cs_n rise
  always_comb begin
    state_n   = state;
    shifter_n = shifter;
    last_n    = last_sent;
    cnt_n     = cnt;
    dout_n    = dout;
    done_n    = 1'b0;
    under_n   = 1'b0;
    abrt_n    = 1'b0;
    case (state)
      IDLE: if (cs_fall) begin
        shifter_n = full ? hold : last_sent;
        last_n    = shifter_n;
        under_n   = ~full;
        dout_n    = shifter_n[DATA_W-1];
        cnt_n     = '0;
        state_n   = SHIFT;
      end
      SHIFT: if (cs_rise) begin
        abrt_n  = 1'b1;
        dout_n  = 1'b0;
        state_n = IDLE;
      end else if (sclk_rise) begin
        cnt_n = cnt + 1'b1;
        if (cnt_n == CW'(DATA_W)) begin
          dout_n  = 1'b0;
          state_n = TAIL;
        end else begin
          shifter_n = shifter << 1;
          dout_n    = shifter_n[DATA_W-1];
        end
      end
      TAIL: if (cs_rise) begin
        done_n  = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  assign bus.from_device = dout;
  assign bus.tx_ready    = ~full;
  assign bus.busy        = state != IDLE;
  assign bus.frame_done  = done;
  assign bus.underrun    = under;
  assign bus.abort       = abrt;
endmodule

// File: tb/tb_spi_slave_tx.sv
// tb_spi_slave_tx: directed SPI master frames with hand-computed expected words
module tb_spi_slave_tx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
  int fd_n = 0, un_n = 0, ab_n = 0;
  int fd0, un0, ab0;
  logic [15:0] cap;
  spi_slave_tx_if #(.DATA_W(12)) bus ();
  spi_slave_tx #(.DATA_W(12), .SYNC_STAGES(2)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (bus.frame_done) fd_n++;
    if (bus.underrun) un_n++;
    if (bus.abort) ab_n++;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic snap();
    fd0 = fd_n; un0 = un_n; ab0 = ab_n;
  endtask
  task automatic write(input logic [11:0] d);
    @(negedge clk);
    bus.tx_valid = 1'b1;
    bus.tx_data  = d;
    @(negedge clk);
    bus.tx_valid = 1'b0;
  endtask
  task automatic frame(input int nbits, input bit wr_en, input logic [11:0] wd, output logic [15:0] c);
    c = '0;
    bus.cs_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("busy_before_latency", 32'(bus.busy), 0);
    bus.tx_valid = wr_en;
    bus.tx_data  = wd;
    @(negedge clk);
    bus.tx_valid = 1'b0;
    chk("busy_at_start", 32'(bus.busy), 1);
    chk("ready_at_start", 32'(bus.tx_ready), 32'(!wr_en));
    repeat (3) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      c = {c[14:0], bus.from_device};
      bus.sclk_n = 1'b0;
      repeat (6) @(negedge clk);
      bus.sclk_n = 1'b1;
      repeat (6) @(negedge clk);
    end
    bus.cs_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("idle_after_frame", 32'(bus.busy), 0);
    chk("dout_idle", 32'(bus.from_device), 0);
  endtask
  initial begin
    bus.sclk_n = 1'b1;
    bus.cs_n = 1'b1;
    bus.tx_valid = 1'b0;
    bus.tx_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_dout", 32'(bus.from_device), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_ready", 32'(bus.tx_ready), 1);
    chk("rst_pulses", {29'd0, bus.frame_done, bus.underrun, bus.abort}, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    snap();
    frame(12, 0, 12'h000, cap);
    chk("empty_after_reset_word", 32'(cap), 32'h000);
    chk("empty_after_reset_underrun", un_n - un0, 1);
    chk("empty_after_reset_done", fd_n - fd0, 1);
    write(12'hA5C);
    chk("ready_low_when_full", 32'(bus.tx_ready), 0);
    snap();
    frame(12, 0, 12'h000, cap);
    chk("a5c_word", 32'(cap), 32'hA5C);
    chk("a5c_no_underrun", un_n - un0, 0);
    chk("a5c_one_done", fd_n - fd0, 1);
    snap();
    frame(12, 0, 12'h000, cap);
    chk("resend_word", 32'(cap), 32'hA5C);
    chk("resend_underrun", un_n - un0, 1);
    write(12'h3F0);
    snap();
    frame(5, 0, 12'h000, cap);
    chk("abort_bits", 32'(cap), 32'h07);
    chk("abort_pulse", ab_n - ab0, 1);
    chk("abort_no_done", fd_n - fd0, 0);
    write(12'h123);
    snap();
    frame(12, 0, 12'h000, cap);
    chk("after_abort_word", 32'(cap), 32'h123);
    chk("after_abort_no_underrun", un_n - un0, 0);
    write(12'hFFF);
    snap();
    frame(14, 0, 12'h000, cap);
    chk("overrun_bits", 32'(cap), 32'h3FFC);
    chk("overrun_one_done", fd_n - fd0, 1);
    write(12'h111);
    write(12'h222);
    chk("second_write_ignored_ready", 32'(bus.tx_ready), 0);
    snap();
    frame(12, 0, 12'h000, cap);
    chk("first_write_kept", 32'(cap), 32'h111);
    snap();
    frame(12, 1, 12'h456, cap);
    chk("coincident_write_resend", 32'(cap), 32'h111);
    chk("coincident_write_underrun", un_n - un0, 1);
    snap();
    frame(12, 0, 12'h000, cap);
    chk("coincident_write_next", 32'(cap), 32'h456);
    chk("coincident_write_next_no_underrun", un_n - un0, 0);
    write(12'h989);
    snap();
    bus.cs_n = 1'b0;
    repeat (8) @(negedge clk);
    chk("midframe_busy", 32'(bus.busy), 1);
    chk("midframe_msb", 32'(bus.from_device), 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_busy", 32'(bus.busy), 0);
    chk("async_rst_dout", 32'(bus.from_device), 0);
    chk("async_rst_ready", 32'(bus.tx_ready), 1);
    bus.cs_n = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("async_rst_no_pulses", (fd_n - fd0) + (ab_n - ab0), 0);
    snap();
    frame(12, 0, 12'h000, cap);
    chk("after_rst_word_lost", 32'(cap), 32'h000);
    chk("after_rst_underrun", un_n - un0, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/spi_slave_tx.md
SPI_SLAVE_TX -- requirements
Module: spi_slave_tx

Interface
REQ-001 SHALL have parameter DATA_W, default 12: frame length in bits, MSB first.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth for sclk_n and cs_n.
REQ-003 SHALL have port clk, input, 1: single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port sclk_n, input, 1: inverted SPI clock from master, asynchronous to clk.
REQ-006 SHALL have port cs_n, input, 1: active-low chip select from master, asynchronous to clk.
REQ-007 SHALL have port from_device, output, 1: serial data to master (MISO).
REQ-008 SHALL have port tx_data, input, DATA_W: word to transmit.
REQ-009 SHALL have port tx_valid, input, 1: tx_data is valid.
REQ-010 SHALL have port tx_ready, output, 1: holding register empty; word accepted when tx_valid && tx_ready.
REQ-011 SHALL have port busy, output, 1: frame in progress (state != IDLE).
REQ-012 SHALL have port frame_done, output, 1: one-clk pulse on completed frame.
REQ-013 SHALL have port underrun, output, 1: one-clk pulse when frame starts with holding register empty.
REQ-014 SHALL have port abort, output, 1: one-clk pulse when cs_n deasserts before DATA_W bits shifted.

Function
REQ-015 SHALL pass sclk_n and cs_n through SYNC_STAGES flops each (reset value 1), then one edge-detect flop.
REQ-016 SHALL hold one word in a holding register with full flag; tx_ready = ~full; accepted write sets full next cycle; tx_valid while full ignored, held word unchanged.
REQ-017 SHALL keep last_sent register (DATA_W bits) holding the last word loaded into the shifter.
REQ-018 SHALL implement states IDLE, SHIFT, TAIL.
REQ-019 IDLE: on detected cs_n falling edge, load shifter with held word if full, else with last_sent and pulse underrun; clear full; drive from_device = shifter MSB; bit counter = 0; go SHIFT.
REQ-020 Write and frame start in the same cycle SHALL count as empty (underrun, resend last_sent); written word stays held for next frame.
REQ-021 SHIFT: on each detected sclk_n rising edge (sclk falling), increment counter; if counter reaches DATA_W, drive from_device = 0 and go TAIL; else shift left and drive next bit.
REQ-022 Master samples on sclk_n falling edge; from_device SHALL be stable across it.
REQ-023 TAIL: from_device held 0; extra sclk_n edges ignored; on cs_n rising edge pulse frame_done, go IDLE.
REQ-024 cs_n rising edge in SHIFT SHALL pulse abort (no frame_done), drive from_device = 0, go IDLE; loaded word counts as consumed.
REQ-025 sclk_n edges in IDLE SHALL be ignored; from_device = 0 in IDLE.
REQ-026 Latency from pin edge to from_device update SHALL be SYNC_STAGES+1 clk cycles.
REQ-027 Correct operation SHALL require sclk_n half-period and cs_n-fall-to-first-sclk-edge each >= SYNC_STAGES+3 clk cycles.
REQ-028 Counter width SHALL be clog2(DATA_W+1); no wrap within a frame.

Reset
REQ-029 On rst: state IDLE, from_device 0, busy 0, tx_ready 1, frame_done 0, underrun 0, abort 0, holding register empty, shifter 0, last_sent 0, synchronizers 1.
REQ-030 rst mid-frame SHALL take effect immediately (asynchronous); frame discarded, no pulses.

Verification
REQ-031 Write 12'hA5C, frame of 12 sclk cycles, half-period 6 clk -> master captures 0xA5C, tx_ready high one cycle after frame start, frame_done exactly one pulse after cs_n rise.
REQ-032 Frame after reset with no write -> underrun pulse, 0x000 sent; after sending 0xA5C, empty frame -> underrun, 0xA5C resent.
REQ-033 cs_n rises after 5 bits of 0x3F0 -> abort pulse, no frame_done; next frame sends next written word 0x123.
REQ-034 14 sclk cycles with 0xFFF loaded -> first 12 bits 1, bits 13-14 read 0, one frame_done.
REQ-035 rst asserted mid-SHIFT -> all outputs at reset values same cycle, held word lost, tx_ready 1.
REQ-036 tx_valid with 0x111 then 0x222 while full -> only 0x111 accepted and transmitted; write coinciding with cs_n fall -> underrun, word sent next frame.
